// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with redirect/stall control and the IF/ID pipeline register.
// instr_addr is driven straight from the PC register, so it has no combinational path from any input.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instruction,
    output logic [31:0] instr_addr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        squash;

    assign pc_plus4   = pc + 32'd4;
    assign squash     = branch_taken | flush;
    assign instr_addr = pc;

    // A redirect outranks a stall; word-align the target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= {branch_target[31:2], 2'b00};
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    // A squash still records the current PC so the bubble carries a meaningful address.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_pc     <= '0;
            ifid_pc4    <= '0;
            ifid_instr  <= NOP_INSTR;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (squash) begin
            ifid_pc    <= pc;
            ifid_pc4   <= pc_plus4;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_pc     <= pc;
            ifid_pc4    <= pc_plus4;
            ifid_instr  <= instruction;
            ifid_valid  <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written wrap/reset sequences,
// then randomized control against a rule-level reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] instruction;
    logic [31:0] instr_addr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instruction   (instruction),
        .instr_addr    (instr_addr),
        .ifid_pc       (ifid_pc),
        .ifid_pc4      (ifid_pc4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count)
    );

    // Instruction memory contents: two fixed words, a hash of the address elsewhere.
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0013;
        if (a == 32'h4) return 32'h0050_0593;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign instruction = memword(instr_addr);

    // Reference model state.
    logic [31:0] m_pc = '0, m_ipc = '0, m_ipc4 = '0, m_instr = NOP, m_cnt = '0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic b, input logic [31:0] t);
        if (r) begin
            m_pc = 32'h0; m_ipc = '0; m_ipc4 = '0; m_instr = NOP; m_valid = 1'b0; m_cnt = '0;
        end else begin
            if (b || f) begin
                m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = NOP; m_valid = 1'b0;
            end else if (!s) begin
                m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = memword(m_pc);
                m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end
            if (b) m_pc = t & 32'hFFFF_FFFC;
            else if (!s) m_pc = m_pc + 32'd4;
        end
    endtask

    // Drive inputs, confirm PC is unaffected combinationally, clock once, compare to model.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic b, input logic [31:0] t);
        rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
        #1;
        chk("addr_no_comb", instr_addr, m_pc);
        model_edge(r, s, f, b, t);
        @(posedge clk);
        #1;
        chk("m_addr", instr_addr, m_pc);
        chk("m_ifid_pc", ifid_pc, m_ipc);
        chk("m_ifid_pc4", ifid_pc4, m_ipc4);
        chk("m_ifid_instr", ifid_instr, m_instr);
        chk("m_ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("m_fetch_count", fetch_count, m_cnt);
    endtask

    typedef struct {
        logic        r, s, f, b;
        logic [31:0] tgt, e_addr, e_ipc, e_instr;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic b,
                                input logic [31:0] t, input logic [31:0] a, input logic [31:0] ip,
                                input logic [31:0] ins, input logic v, input logic [31:0] c);
        vec_t x;
        x.r = r; x.s = s; x.f = f; x.b = b; x.tgt = t;
        x.e_addr = a; x.e_ipc = ip; x.e_instr = ins; x.e_valid = v; x.e_cnt = c;
        return x;
    endfunction

    vec_t vecs[16];

    initial begin
        // Reset, run, stall at 0x10, redirects to 0x3C and 0x2D, simultaneous events.
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,  32'h00, 32'h00, NOP,             0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h0,  32'h00, 32'h00, NOP,             0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,  32'h04, 32'h00, 32'h00A0_0013,   1, 1);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,  32'h08, 32'h04, 32'h0050_0593,   1, 2);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,  32'h0C, 32'h08, memword(32'h08), 1, 3);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,  32'h10, 32'h0C, memword(32'h0C), 1, 4);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,  32'h10, 32'h0C, memword(32'h0C), 1, 4);
        vecs[7]  = mk(0, 1, 0, 0, 32'h0,  32'h10, 32'h0C, memword(32'h0C), 1, 4);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,  32'h14, 32'h10, memword(32'h10), 1, 5);
        vecs[9]  = mk(0, 0, 0, 1, 32'h3C, 32'h3C, 32'h14, NOP,             0, 5);
        vecs[10] = mk(0, 0, 0, 1, 32'h2D, 32'h2C, 32'h3C, NOP,             0, 5);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,  32'h30, 32'h2C, memword(32'h2C), 1, 6);
        vecs[12] = mk(0, 1, 0, 1, 32'h20, 32'h20, 32'h30, NOP,             0, 6);
        vecs[13] = mk(0, 1, 1, 0, 32'h0,  32'h20, 32'h20, NOP,             0, 6);
        vecs[14] = mk(0, 0, 1, 0, 32'h0,  32'h24, 32'h20, NOP,             0, 6);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,  32'h28, 32'h24, memword(32'h24), 1, 7);

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].b, vecs[i].tgt);
            chk($sformatf("v%0d_addr", i), instr_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_ifid_pc", i), ifid_pc, vecs[i].e_ipc);
            chk($sformatf("v%0d_ifid_pc4", i), ifid_pc4,
                vecs[i].r ? 32'h0 : vecs[i].e_ipc + 32'd4);
            chk($sformatf("v%0d_ifid_instr", i), ifid_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_fetch_count", i), fetch_count, vecs[i].e_cnt);
        end

        // PC wrap at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_redirect_addr", instr_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0);
        chk("wrap_addr", instr_addr, 32'h0000_0000);
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_pc4", ifid_pc4, 32'h0000_0000);
        chk("wrap_valid", {31'b0, ifid_valid}, 32'd1);

        // Reset during stall, then during a redirect, then resume at RESET_PC.
        step(0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        chk("rst_stall_addr", instr_addr, 32'h0);
        chk("rst_stall_ifid_pc", ifid_pc, 32'h0);
        chk("rst_stall_ifid_pc4", ifid_pc4, 32'h0);
        chk("rst_stall_instr", ifid_instr, NOP);
        chk("rst_stall_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_stall_count", fetch_count, 32'd0);
        step(0, 0, 0, 0, 32'h0);
        step(1, 0, 1, 1, 32'h0000_0100);
        chk("rst_br_addr", instr_addr, 32'h0);
        chk("rst_br_count", fetch_count, 32'd0);
        step(0, 0, 0, 0, 32'h0);
        chk("resume_addr", instr_addr, 32'h4);
        chk("resume_instr", ifid_instr, 32'h00A0_0013);
        chk("resume_count", fetch_count, 32'd1);

        // Randomized control traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, bubble encoding (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard-unit hold request for PC and IF/ID.
REQ-006 SHALL have port flush  input  1  squash request for IF/ID contents.
REQ-007 SHALL have port branch_taken  input  1  redirect request from EX.
REQ-008 SHALL have port branch_target  input  32  redirect byte address.
REQ-009 SHALL have port instruction  input  32  fetched word from instruction memory, combinational, little-endian byte assembly.
REQ-010 SHALL have port instr_addr  output  32  current PC driven to instruction memory.
REQ-011 SHALL have port ifid_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 SHALL have port ifid_pc4  output  32  ifid_pc + 4.
REQ-013 SHALL have port ifid_instr  output  32  instruction held in IF/ID.
REQ-014 SHALL have port ifid_valid  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-015 SHALL have port fetch_count  output  32  number of valid instructions latched into IF/ID since reset.

Function
REQ-016 instr_addr SHALL equal the PC register directly, with no combinational path from any input.
REQ-017 Per edge, PC update priority SHALL be: rst > branch_taken > stall > normal increment.
REQ-018 On branch_taken, PC SHALL load {branch_target[31:2],2'b00}; low two target bits are ignored.
REQ-019 On stall without branch_taken, PC SHALL hold its value.
REQ-020 On normal increment, PC SHALL load PC+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-021 Per edge, IF/ID update priority SHALL be: rst > (branch_taken or flush) > stall > load.
REQ-022 Squash SHALL set ifid_instr=NOP_INSTR, ifid_valid=0, and ifid_pc=PC; a squash overrides a concurrent stall.
REQ-023 On stall without squash, ifid_pc, ifid_instr and ifid_valid SHALL hold.
REQ-024 On load, the block SHALL set ifid_pc=PC, ifid_instr=instruction, ifid_valid=1.
REQ-025 ifid_pc4 SHALL be registered as PC+4 in the same edge that loads ifid_pc, wrapping modulo 2^32.
REQ-026 fetch_count SHALL increment by 1, wrapping at 2^32, exactly on edges that perform a load (REQ-024); otherwise it holds.
REQ-027 Fetch-to-IF/ID latency SHALL be one cycle: the word presented at instr_addr=A appears on ifid_instr after the next edge, absent stall or squash.
REQ-028 After a redirect edge, the first target instruction SHALL appear in IF/ID one further edge later, giving exactly one bubble.

Reset
REQ-029 On rst, the block SHALL set PC=RESET_PC, ifid_pc=0, ifid_pc4=0, ifid_instr=NOP_INSTR, ifid_valid=0, fetch_count=0, regardless of other inputs.
REQ-030 Reset asserted mid-stream, including during stall or redirect, SHALL take effect at that edge; fetch SHALL resume at RESET_PC on the first edge with rst low.

Verification
REQ-031 Reset then run: rst high 2 cycles; memory returns 0x00A00013 at 0 and 0x00500593 at 4 -> instr_addr 0,4,8; ifid_instr 0x00A00013 then 0x00500593; ifid_valid=1; fetch_count=2 after two loads.
REQ-032 Stall: assert stall 2 cycles at PC=0x10 -> instr_addr stays 0x10, IF/ID unchanged, fetch_count unchanged; release -> PC=0x14 next edge.
REQ-033 Redirect: at PC=0x3C, branch_taken=1 with target 0x2D -> instr_addr=0x2C; ifid_valid=0, ifid_instr=0x00000013; the next edge loads the word at 0x2C.
REQ-034 Simultaneous events: branch_taken=1, stall=1, target 0x20 -> PC=0x20 and IF/ID squashed; flush=1 with stall=1 -> PC holds and IF/ID squashed.
REQ-035 Wrap and reset: PC forced to 0xFFFFFFFC via redirect -> next PC 0x00000000 and ifid_pc4=0; rst during stall -> all outputs match REQ-029 next edge.
